eater_loader: RTL

Serial program loader for the 8-bit eater CPU. It receives a framed 16-byte program image over a UART line and writes it into the CPU's 16×8 RAM through a dedicated write port, holding the CPU in reset while the load is in progress. On a valid checksum it releases the CPU to run from `RESET_PC`. It is the writer side of the program RAM that the CPU reads, and replaces the `$readmemh` preload in the field.

---
 rtl/eater_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/eater_loader.sv
// Serial program loader for the eater CPU: receives a sync byte, 16 data bytes and a
// checksum over an 8N1 UART line, writes the data to program RAM and holds the CPU in reset meanwhile.
module eater_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       ram_we_o,
  output logic [3:0] ram_addr_o,
  output logic [7:0] ram_data_o,
  output logic       cpu_reset_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_DATA, F_CHECK} f_state_e;

  // Receiver state
  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid;
  logic          frame_err;

  // Frame state and registered outputs
  f_state_e   f_state_q, f_state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic       ram_we_q, ram_we_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rx_meta_d  = rx_i;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start sample; a high line here means the falling edge was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d      = '0;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    f_state_d   = f_state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    unique case (f_state_q)
      F_IDLE: begin
        if (byte_valid && shift_q == SYNC_BYTE) begin
          f_state_d   = F_DATA;
          idx_d       = '0;
          sum_d       = '0;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      F_DATA: begin
        if (byte_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = idx_q;
          ram_data_d = shift_q;
          sum_d      = sum_q + shift_q;
          idx_d      = idx_q + 4'd1;
          if (idx_q == 4'd15) f_state_d = F_CHECK;
        end else if (frame_err) begin
          error_d   = 1'b1;
          busy_d    = 1'b0;
          f_state_d = F_IDLE;
        end
      end
      F_CHECK: begin
        if (byte_valid) begin
          busy_d    = 1'b0;
          f_state_d = F_IDLE;
          if (shift_q == sum_q) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            // RAM holds a corrupt image, so the CPU stays in reset.
            error_d = 1'b1;
          end
        end else if (frame_err) begin
          error_d   = 1'b1;
          busy_d    = 1'b0;
          f_state_d = F_IDLE;
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      f_state_q   <= F_IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      f_state_q   <= f_state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
